// File: rtl/cpr_loader.sv
`default_nettype none
// ============================================================================
// Module      : cpr_loader
// Description : Streams an Amstrad CPR cartridge image (RIFF "AMS!" container)
//               from the ioctl download port into banked cartridge ROM.
//               The RIFF header is checked, each chunk id/length is parsed, and
//               "cbNN" chunk payloads are written to {bank, offset}. Other
//               chunks and pad bytes are consumed without writes.
// Ports       : clk_sys, reset           - clock, synchronous active-high reset
//               ioctl_download/wr/index/dout - byte source (in)
//               ioctl_wait                - stall to byte source (= mem_wr)
//               mem_addr/mem_din/mem_wr   - ROM write request, held until ack
//               mem_ack                   - write-complete pulse (in)
//               busy/done/error           - parse status
//               bank_count                - highest written bank + 1
// Revision    : 1.0 - initial release
// ============================================================================
module cpr_loader #(
    parameter int         BANK_BITS = 5,
    parameter logic [7:0] CPR_INDEX = 8'd5
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   ioctl_download,
    input  logic                   ioctl_wr,
    input  logic [7:0]             ioctl_index,
    input  logic [7:0]             ioctl_dout,
    output logic                   ioctl_wait,
    output logic [BANK_BITS+13:0]  mem_addr,
    output logic [7:0]             mem_din,
    output logic                   mem_wr,
    input  logic                   mem_ack,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [BANK_BITS:0]     bank_count
);

    localparam logic [3:0] c_st_idle = 4'd0;
    localparam logic [3:0] c_st_hdr  = 4'd1;
    localparam logic [3:0] c_st_id   = 4'd2;
    localparam logic [3:0] c_st_len  = 4'd3;
    localparam logic [3:0] c_st_data = 4'd4;
    localparam logic [3:0] c_st_skip = 4'd5;
    localparam logic [3:0] c_st_pad  = 4'd6;
    localparam logic [3:0] c_st_done = 4'd7;
    localparam logic [3:0] c_st_err  = 4'd8;

    localparam logic [BANK_BITS:0] c_one = {{BANK_BITS{1'b0}}, 1'b1};

    logic [3:0]            r_state;
    logic                  r_dl_q;
    logic                  r_fall_pend;
    logic [3:0]            r_cnt;
    logic [31:0]           r_id;
    logic [31:0]           r_len;
    logic [31:0]           r_pos;
    logic [BANK_BITS-1:0]  r_bank;
    logic                  r_mem_wr;
    logic [BANK_BITS+13:0] r_mem_addr;
    logic [7:0]            r_mem_din;
    logic [BANK_BITS:0]    r_bank_count;

    logic                  w_dl;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_acc;
    logic [3:0]            w_state;
    logic [3:0]            w_cnt;
    logic [7:0]            w_hdr_exp;
    logic                  w_hdr_care;
    logic [31:0]           w_len_next;
    logic [31:0]           w_pos_inc;
    logic                  w_last;
    logic                  w_id_ok;
    logic [6:0]            w_bank_num;
    logic [31:0]           w_bank_ext;
    logic                  w_bank_fits;
    logic [BANK_BITS:0]    w_bank_plus1;

    // Only downloads of our own index are visible to the parser at all.
    assign w_dl   = ioctl_download && (ioctl_index == CPR_INDEX);
    assign w_rise = w_dl && !r_dl_q;
    assign w_fall = !w_dl && r_dl_q;
    assign w_acc  = w_dl && ioctl_wr && !r_mem_wr;

    // A byte arriving on the very cycle the download starts is byte 0 of the
    // header, so the parser looks through the start-of-download reset.
    assign w_state = w_rise ? c_st_hdr : r_state;
    assign w_cnt   = w_rise ? 4'd0 : r_cnt;

    always_comb begin
        w_hdr_exp = 8'h00;
        case (w_cnt)
            4'd0:    w_hdr_exp = 8'h52; // R
            4'd1:    w_hdr_exp = 8'h49; // I
            4'd2:    w_hdr_exp = 8'h46; // F
            4'd3:    w_hdr_exp = 8'h46; // F
            4'd8:    w_hdr_exp = 8'h41; // A
            4'd9:    w_hdr_exp = 8'h4D; // M
            4'd10:   w_hdr_exp = 8'h53; // S
            4'd11:   w_hdr_exp = 8'h21; // !
            default: w_hdr_exp = 8'h00;
        endcase
    end

    // Bytes 4-7 carry the RIFF size, which the parser does not need.
    assign w_hdr_care = (w_cnt < 4'd4) || (w_cnt >= 4'd8);

    // Length arrives LSB first; shifting in from the top leaves it aligned.
    assign w_len_next = {ioctl_dout, r_len[31:8]};
    assign w_pos_inc  = r_pos + 32'd1;
    assign w_last     = (w_pos_inc == r_len);

    // r_id holds the id with its first character in the top byte. The low
    // nibble of an ASCII digit is its value, so no subtraction is needed.
    assign w_id_ok = (r_id[31:24] == 8'h63) && (r_id[23:16] == 8'h62) &&
                     (r_id[15:8] >= 8'h30) && (r_id[15:8] <= 8'h39) &&
                     (r_id[7:0]  >= 8'h30) && (r_id[7:0]  <= 8'h39);
    assign w_bank_num   = ({3'b000, r_id[11:8]} << 3) + ({3'b000, r_id[11:8]} << 1)
                        + {3'b000, r_id[3:0]};
    assign w_bank_ext   = {25'd0, w_bank_num};
    assign w_bank_fits  = w_bank_ext < (32'd1 << BANK_BITS);
    assign w_bank_plus1 = {1'b0, r_bank} + c_one;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_dl_q       <= 1'b0;
            r_fall_pend  <= 1'b0;
            r_cnt        <= 4'd0;
            r_id         <= 32'd0;
            r_len        <= 32'd0;
            r_pos        <= 32'd0;
            r_bank       <= '0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= 8'd0;
            r_bank_count <= '0;
        end else begin
            r_dl_q <= w_dl;

            if (r_mem_wr && mem_ack) begin
                r_mem_wr <= 1'b0;
            end

            if (w_rise) begin
                r_state      <= c_st_hdr;
                r_cnt        <= 4'd0;
                r_bank_count <= '0;
                r_fall_pend  <= 1'b0;
            end

            if (w_acc) begin
                case (w_state)
                    c_st_hdr: begin
                        if (w_hdr_care && (ioctl_dout != w_hdr_exp)) begin
                            r_state <= c_st_err;
                        end else if (w_cnt == 4'd11) begin
                            r_state <= c_st_id;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_cnt <= w_cnt + 4'd1;
                        end
                    end
                    c_st_id: begin
                        r_id <= {r_id[23:0], ioctl_dout};
                        if (w_cnt == 4'd3) begin
                            r_state <= c_st_len;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_cnt <= w_cnt + 4'd1;
                        end
                    end
                    c_st_len: begin
                        r_len <= w_len_next;
                        if (w_cnt == 4'd3) begin
                            r_cnt <= 4'd0;
                            r_pos <= 32'd0;
                            if (w_len_next == 32'd0) begin
                                r_state <= c_st_id;
                            end else if (!(w_id_ok && w_bank_fits)) begin
                                r_state <= c_st_skip;
                            end else begin
                                r_state <= c_st_data;
                                r_bank  <= w_bank_ext[BANK_BITS-1:0];
                            end
                        end else begin
                            r_cnt <= w_cnt + 4'd1;
                        end
                    end
                    c_st_data, c_st_skip: begin
                        // Payload past one bank is drained but never written.
                        if ((w_state == c_st_data) && (r_pos[31:14] == 18'd0)) begin
                            r_mem_wr   <= 1'b1;
                            r_mem_addr <= {r_bank, r_pos[13:0]};
                            r_mem_din  <= ioctl_dout;
                            if (w_bank_plus1 > r_bank_count) begin
                                r_bank_count <= w_bank_plus1;
                            end
                        end
                        r_pos <= w_pos_inc;
                        if (w_last) begin
                            r_state <= r_len[0] ? c_st_pad : c_st_id;
                            r_cnt   <= 4'd0;
                        end
                    end
                    c_st_pad: begin
                        r_state <= c_st_id;
                        r_cnt   <= 4'd0;
                    end
                    default: begin
                        // Idle, done and error states discard bytes.
                    end
                endcase
            end else if (!w_rise && (w_fall || r_fall_pend)) begin
                // End of download: let an outstanding write finish first so a
                // clean end is only reported once every byte is in ROM.
                if (r_mem_wr && !mem_ack) begin
                    r_fall_pend <= 1'b1;
                end else begin
                    r_fall_pend <= 1'b0;
                    case (r_state)
                        c_st_id:   r_state <= (r_cnt == 4'd0) ? c_st_done : c_st_err;
                        c_st_hdr,
                        c_st_len,
                        c_st_data,
                        c_st_skip,
                        c_st_pad:  r_state <= c_st_err;
                        default:   r_state <= r_state;
                    endcase
                end
            end
        end
    end

    assign ioctl_wait = r_mem_wr;
    assign mem_wr     = r_mem_wr;
    assign mem_addr   = r_mem_addr;
    assign mem_din    = r_mem_din;
    assign bank_count = r_bank_count;
    assign busy       = (r_state == c_st_hdr)  || (r_state == c_st_id)   ||
                        (r_state == c_st_len)  || (r_state == c_st_data) ||
                        (r_state == c_st_skip) || (r_state == c_st_pad);
    assign done       = (r_state == c_st_done);
    assign error      = (r_state == c_st_err);

endmodule
`default_nettype wire

// File: tb/tb_cpr_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpr_loader
// Description : Self-checking bench for cpr_loader. Expected ROM writes are
//               queued as the file is streamed and popped by a memory
//               responder that also acknowledges each write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpr_loader;

    localparam int BANK_BITS = 5;
    localparam int AW        = BANK_BITS + 14;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [7:0]        ioctl_index;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wait;
    logic [AW-1:0]     mem_addr;
    logic [7:0]        mem_din;
    logic              mem_wr;
    logic              mem_ack;
    logic              busy;
    logic              done;
    logic              error;
    logic [BANK_BITS:0] bank_count;

    logic resp_ack;
    logic force_ack;
    assign mem_ack = resp_ack | force_ack;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t exp_q[$];
    int  checks;
    int  errors;
    int  wr_count;
    int  ack_delay;
    bit  ack_en;

    cpr_loader #(.BANK_BITS(BANK_BITS), .CPR_INDEX(8'd5)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_wr         (mem_wr),
        .mem_ack        (mem_ack),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .bank_count     (bank_count)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Memory side: checks every new write against the queue, then acks it
    // ack_delay negedges later (ack sampled ack_delay+1 cycles after mem_wr).
    task automatic responder();
        bit  seen   = 1'b0;
        int  wait_n = 0;
        wr_t e;
        forever begin
            @(negedge clk_sys);
            if (mem_wr && !seen) begin
                seen   = 1'b1;
                wait_n = ack_delay;
                wr_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected addr=%h din=%h, required no write", mem_addr, mem_din);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_addr !== e.addr || mem_din !== e.data) begin
                        errors++;
                        $display("FAIL wr_data addr=%h din=%h, required addr=%h din=%h",
                                 mem_addr, mem_din, e.addr, e.data);
                    end
                end
            end
            if (!mem_wr) seen = 1'b0;
            if (resp_ack) begin
                resp_ack = 1'b0;
            end else if (mem_wr && seen && ack_en) begin
                if (wait_n == 0) resp_ack = 1'b1;
                else wait_n--;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (ioctl_wait !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL byte_stall ioctl_wait=%b after %0d cycles, required 0", ioctl_wait, n);
        end
        ioctl_dout = b;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic send_len(input logic [31:0] l);
        for (int i = 0; i < 4; i++) send_byte(l[i*8 +: 8]);
    endtask

    task automatic send_hdr();
        send_word("RIFF");
        send_word(32'h1234_5678);
        send_word("AMS!");
    endtask

    task automatic start_dl();
        ioctl_index    = 8'd5;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic stop_dl();
        ioctl_download = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || mem_wr !== 1'b0) && n < 500) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL drain pending=%0d mem_wr=%b, required 0 and 0", exp_q.size(), mem_wr);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({mem_wr, ioctl_wait, busy, done, error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags wr/wait/busy/done/err=%b, required 00000",
                     {mem_wr, ioctl_wait, busy, done, error});
        end
        checks++;
        if (bank_count !== '0 || mem_addr !== '0 || mem_din !== 8'd0) begin
            errors++;
            $display("FAIL reset_values bank_count=%0d addr=%h din=%h, required 0 0 0",
                     bank_count, mem_addr, mem_din);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int w0 = wr_count;
        ack_delay = 1;
        start_dl();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_start busy=%b done=%b, required 1 0", busy, done);
        end
        send_hdr();
        send_word("cb00");
        send_len(32'd4);
        push_exp(19'h00000, 8'h11);
        push_exp(19'h00001, 8'h22);
        push_exp(19'h00002, 8'h33);
        push_exp(19'h00003, 8'h44);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        wait_drain();
        stop_dl();
        checks++;
        if ({busy, done, error} !== 3'b010 || bank_count !== 6'd1) begin
            errors++;
            $display("FAIL basic_end busy/done/err=%b bank_count=%0d, required 010 1",
                     {busy, done, error}, bank_count);
        end
        checks++;
        if (wr_count - w0 != 4) begin
            errors++;
            $display("FAIL basic_writes count=%0d, required 4", wr_count - w0);
        end
    endtask

    task automatic test_bad_header();
        int w0 = wr_count;
        start_dl();
        checks++;
        if (done !== 1'b0 || bank_count !== '0) begin
            errors++;
            $display("FAIL restart_clear done=%b bank_count=%0d, required 0 0", done, bank_count);
        end
        send_byte("X");
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL badhdr_err error=%b busy=%b, required 1 0", error, busy);
        end
        send_word("cb00");
        send_byte(8'h99);
        stop_dl();
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || wr_count != w0) begin
            errors++;
            $display("FAIL badhdr_hold error=%b done=%b writes=%0d, required 1 0 0",
                     error, done, wr_count - w0);
        end
    endtask

    task automatic test_odd_pad();
        int w0 = wr_count;
        start_dl();
        send_hdr();
        send_word("cb31");
        send_len(32'd3);
        push_exp(19'h7C000, 8'hA0);
        push_exp(19'h7C001, 8'hA1);
        push_exp(19'h7C002, 8'hA2);
        send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2);
        send_byte(8'hEE);
        send_word("cb02");
        send_len(32'd1);
        push_exp(19'h08000, 8'hB0);
        send_byte(8'hB0);
        send_byte(8'hEF);
        wait_drain();
        stop_dl();
        checks++;
        if (done !== 1'b1 || bank_count !== 6'd32 || wr_count - w0 != 4) begin
            errors++;
            $display("FAIL odd_pad done=%b bank_count=%0d writes=%0d, required 1 32 4",
                     done, bank_count, wr_count - w0);
        end
    endtask

    task automatic test_skip_chunk();
        int w0 = wr_count;
        start_dl();
        send_hdr();
        send_word("fmt ");
        send_len(32'd2);
        send_byte(8'h01); send_byte(8'h02);
        send_word("cb01");
        send_len(32'd1);
        push_exp(19'h04000, 8'h5A);
        send_byte(8'h5A);
        send_byte(8'h00);
        wait_drain();
        stop_dl();
        checks++;
        if (done !== 1'b1 || bank_count !== 6'd2 || wr_count - w0 != 1) begin
            errors++;
            $display("FAIL skip_chunk done=%b bank_count=%0d writes=%0d, required 1 2 1",
                     done, bank_count, wr_count - w0);
        end
    endtask

    task automatic test_other_index();
        int w0 = wr_count;
        ioctl_index    = 8'd3;
        ioctl_download = 1'b1;
        tick();
        send_hdr();
        send_word("cb00");
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || bank_count !== 6'd2 || wr_count != w0) begin
            errors++;
            $display("FAIL other_index busy=%b done=%b bank_count=%0d writes=%0d, required 0 1 2 0",
                     busy, done, bank_count, wr_count - w0);
        end
        ioctl_download = 1'b0;
        tick();
        ioctl_index = 8'd5;
    endtask

    task automatic test_boundary();
        int w0 = wr_count;
        logic [31:0] v;
        ack_delay = 0;
        start_dl();
        send_hdr();
        send_word("cb00");
        send_len(32'd16386);
        for (int i = 0; i < 16386; i++) begin
            v = i;
            if (i < 16384) push_exp({5'd0, v[13:0]}, v[7:0] ^ 8'h3C);
            send_byte(v[7:0] ^ 8'h3C);
        end
        wait_drain();
        checks++;
        if (busy !== 1'b1 || error !== 1'b0 || wr_count - w0 != 16384) begin
            errors++;
            $display("FAIL bound_count busy=%b error=%b writes=%0d, required 1 0 16384",
                     busy, error, wr_count - w0);
        end
        checks++;
        if (mem_addr !== 19'h03FFF) begin
            errors++;
            $display("FAIL bound_last addr=%h, required 03fff", mem_addr);
        end
        stop_dl();
        checks++;
        if (done !== 1'b1 || bank_count !== 6'd1) begin
            errors++;
            $display("FAIL bound_done done=%b bank_count=%0d, required 1 1", done, bank_count);
        end
        ack_delay = 1;
    endtask

    task automatic test_abort_and_reset();
        start_dl();
        send_hdr();
        send_word("cb00");
        send_len(32'd4);
        push_exp(19'h00000, 8'hA1);
        push_exp(19'h00001, 8'hA2);
        send_byte(8'hA1); send_byte(8'hA2);
        wait_drain();
        stop_dl();
        checks++;
        if ({busy, done, error} !== 3'b001) begin
            errors++;
            $display("FAIL abort_err busy/done/err=%b, required 001", {busy, done, error});
        end
        start_dl();
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart error=%b busy=%b, required 0 1", error, busy);
        end
        send_hdr();
        send_word("cb00");
        send_len(32'd4);
        ack_en = 1'b0;
        push_exp(19'h00000, 8'hC1);
        send_byte(8'hC1);
        tick();
        checks++;
        if (mem_wr !== 1'b1 || ioctl_wait !== 1'b1) begin
            errors++;
            $display("FAIL pend_hold mem_wr=%b ioctl_wait=%b, required 1 1", mem_wr, ioctl_wait);
        end
        reset          = 1'b1;
        ioctl_download = 1'b0;
        tick();
        checks++;
        if ({mem_wr, ioctl_wait, busy, done, error} !== 5'b0 || bank_count !== '0 ||
            mem_addr !== '0 || mem_din !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid flags=%b bank_count=%0d addr=%h din=%h, required 00000 0 0 0",
                     {mem_wr, ioctl_wait, busy, done, error}, bank_count, mem_addr, mem_din);
        end
        reset     = 1'b0;
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        tick();
        checks++;
        if (mem_wr !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL late_ack mem_wr=%b busy=%b pending=%0d, required 0 0 0",
                     mem_wr, busy, exp_q.size());
        end
        ack_en = 1'b1;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        wr_count       = 0;
        ack_delay      = 1;
        ack_en         = 1'b1;
        resp_ack       = 1'b0;
        force_ack      = 1'b0;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_index    = 8'd5;
        ioctl_dout     = 8'd0;
        fork
            responder();
        join_none
        repeat (3) tick();
        test_reset();
        test_basic();
        test_bad_header();
        test_odd_pad();
        test_skip_chunk();
        test_other_index();
        test_boundary();
        test_abort_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpr_loader.md
CPR_LOADER -- requirements
Module: cpr_loader

Interface
REQ-001 SHALL have parameter BANK_BITS, default 5, meaning bank-number width (2^BANK_BITS banks of 16 KiB).
REQ-002 SHALL have parameter CPR_INDEX, default 8'd5, meaning the ioctl_index value that selects CPR downloads.
REQ-003 clk_sys  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ioctl_download  in  1  download window active.
REQ-006 ioctl_wr  in  1  byte strobe, one cycle per byte.
REQ-007 ioctl_index  in  8  download type.
REQ-008 ioctl_dout  in  8  streamed file byte.
REQ-009 ioctl_wait  out  1  stall request to the byte source.
REQ-010 mem_addr  out  BANK_BITS+14  ROM write address {bank, offset[13:0]}.
REQ-011 mem_din  out  8  ROM write data.
REQ-012 mem_wr  out  1  write request, level, held until acknowledged.
REQ-013 mem_ack  in  1  write-complete pulse from the memory arbiter.
REQ-014 busy  out  1  parse in progress.
REQ-015 done  out  1  last parse completed cleanly.
REQ-016 error  out  1  last parse failed.
REQ-017 bank_count  out  BANK_BITS+1  highest written bank + 1.

Function
REQ-018 A byte SHALL be accepted only when ioctl_download & ioctl_wr & (ioctl_index==CPR_INDEX) & !ioctl_wait; the file is consumed strictly in stream order, and ioctl_addr is not used.
REQ-019 Rising edge of the qualified ioctl_download SHALL enter HDR and clear done, error, bank_count, and the byte counter, from any state.
REQ-020 HDR SHALL consume 12 bytes: bytes 0-3 must equal "RIFF", bytes 4-7 are ignored, bytes 8-11 must equal "AMS!"; the first mismatching byte SHALL go to ERR.
REQ-021 ID SHALL consume 4 bytes; a valid bank id is "c","b",digit,digit (ASCII 0x30-0x39), bank = 10*d1 + d0.
REQ-022 LEN SHALL consume 4 bytes, little-endian, into a 32-bit length register.
REQ-023 After LEN: length 0 goes to ID; an invalid id or bank >= 2^BANK_BITS goes to SKIP; otherwise the state goes to DATA with offset = 0.
REQ-024 DATA SHALL write each accepted byte to {bank, offset} and then increment offset.
REQ-025 Bytes beyond offset 16383 SHALL be consumed without a write.
REQ-026 The chunk ends after exactly length bytes.
REQ-027 SKIP SHALL consume length bytes without writes.
REQ-028 At the end of a chunk with odd length, PAD SHALL consume exactly 1 byte; the state then returns to ID.
REQ-029 mem_wr SHALL rise the cycle after a DATA byte is accepted, with mem_addr and mem_din stable, and SHALL fall the cycle after mem_ack is sampled high.
REQ-030 ioctl_wait SHALL equal mem_wr.
REQ-031 mem_ack while mem_wr is low SHALL be ignored.
REQ-032 On the first write to a bank, bank_count SHALL become max(bank_count, bank+1).
REQ-033 Falling edge of ioctl_download in ID with 0 id bytes consumed, with no write pending, SHALL go to DONE.
REQ-034 A falling edge in any other non-IDLE, non-terminal state SHALL go to ERR.
REQ-035 If the falling edge arrives with a write pending, the state transition SHALL wait for mem_ack.
REQ-036 DONE SHALL drive done=1; ERR SHALL drive error=1; both SHALL hold until the next download start or reset.
REQ-037 busy SHALL be 1 in HDR, ID, LEN, DATA, SKIP, and PAD, and 0 otherwise.
REQ-038 Downloads with any other ioctl_index SHALL be ignored entirely and SHALL leave outputs unchanged.
REQ-039 In ERR, further bytes SHALL be accepted and discarded, with no writes.

Reset
REQ-040 reset SHALL force IDLE, drop mem_wr and ioctl_wait immediately, and clear done, error, busy, bank_count, mem_addr, and mem_din to 0.
REQ-041 reset mid-write SHALL abandon the write, and a later mem_ack SHALL be ignored.

Verification
REQ-042 Scenario 1: header "RIFF",xx×4,"AMS!" + "cb00" len 4 bytes 11 22 33 44, mem_ack 2 cycles after each mem_wr, then download falls -> writes 0x11..0x44 to addresses 0..3, bank_count=1, done=1.
REQ-043 Scenario 2: header byte 0 = "X" -> error=1, no mem_wr ever.
REQ-044 Scenario 3: "cb31" len 3 (odd) + pad + "cb02" len 1 -> bank 31 offsets 0-2 written, pad skipped, bank 2 offset 0 written (address 0x8000), bank_count=32.
REQ-045 Scenario 4: "fmt " len 2, then "cb01" len 1 -> fmt chunk skipped with no writes, 1 write to 0x4000.
REQ-046 Scenario 5: "cb00" len 16386 -> exactly 16384 writes, last at 0x3FFF, then ID state.
REQ-047 Scenario 6: download falls mid-DATA -> error=1; assert reset during pending mem_wr -> mem_wr=0 next cycle, all outputs 0.
